// File: rtl/sysmgr_pkg.sv
// rtl/sysmgr_pkg.sv - state encoding, default parameters and width helper for the reset sequencer
package sysmgr_pkg;

  localparam int N_CH_DEF      = 3;
  localparam int LOCK_FILT_DEF = 4;
  localparam int STRETCH_DEF   = 8;
  localparam int GAP_DEF       = 4;
  localparam int LOST_W_DEF    = 8;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STRETCH   = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  // Counter width for a terminal count of v; never narrower than one bit.
  function automatic int cnt_w(input int v);
    return $clog2((v < 2) ? 2 : v);
  endfunction

endpackage

// File: rtl/sysmgr_sync2.sv
// rtl/sysmgr_sync2.sv - two-flop synchroniser for asynchronous status inputs
module sysmgr_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sysmgr_rst_seq.sv
// rtl/sysmgr_rst_seq.sv - lock-gated reset sequencer releasing channels in index order
module sysmgr_rst_seq
  import sysmgr_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int LOCK_FILT = LOCK_FILT_DEF,
  parameter int STRETCH   = STRETCH_DEF,
  parameter int GAP       = GAP_DEF,
  parameter int LOST_W    = LOST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_lock,
  input  logic              sw_rst_req,
  output logic [N_CH-1:0]   ch_rst,
  output logic              ready,
  output logic [LOST_W-1:0] lost_cnt,
  output logic [1:0]        state
);

  localparam int FILT_W = cnt_w(LOCK_FILT);
  localparam int STR_W  = cnt_w(STRETCH);
  localparam int GAP_W  = cnt_w(GAP);
  localparam int IDX_W  = cnt_w(N_CH);

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
  localparam logic [STR_W-1:0]  STR_LAST  = STR_W'(STRETCH - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH - 1);

  logic lock_s;

  state_e              state_q, state_d;
  logic [FILT_W-1:0]   filt_q, filt_d;
  logic [STR_W-1:0]    str_q, str_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_CH-1:0]     ch_rst_q, ch_rst_d;
  logic                ready_q, ready_d;
  logic [LOST_W-1:0]   lost_q, lost_d;

  sysmgr_sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_WAIT_LOCK;
      filt_q   <= '0;
      str_q    <= '0;
      gap_q    <= '0;
      idx_q    <= '0;
      ch_rst_q <= '1;
      ready_q  <= 1'b0;
      lost_q   <= '0;
    end else begin
      state_q  <= state_d;
      filt_q   <= filt_d;
      str_q    <= str_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      ch_rst_q <= ch_rst_d;
      ready_q  <= ready_d;
      lost_q   <= lost_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    filt_d   = filt_q;
    str_d    = str_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    ch_rst_d = ch_rst_q;
    ready_d  = ready_q;
    lost_d   = lost_q;

    if (state_q == ST_WAIT_LOCK) begin
      ch_rst_d = '1;
      ready_d  = 1'b0;
      if (!lock_s) begin
        filt_d = '0;
      end else if (filt_q == FILT_LAST) begin
        filt_d  = '0;
        state_d = ST_STRETCH;
      end else begin
        filt_d = filt_q + FILT_W'(1);
      end
    end else if (!lock_s) begin
      // Lock loss outranks a simultaneous software request.
      state_d  = ST_WAIT_LOCK;
      filt_d   = '0;
      str_d    = '0;
      gap_d    = '0;
      idx_d    = '0;
      ch_rst_d = '1;
      ready_d  = 1'b0;
      if (lost_q != {LOST_W{1'b1}}) lost_d = lost_q + LOST_W'(1);
    end else if (sw_rst_req) begin
      state_d  = ST_STRETCH;
      str_d    = '0;
      gap_d    = '0;
      idx_d    = '0;
      ch_rst_d = '1;
      ready_d  = 1'b0;
    end else begin
      case (state_q)
        ST_STRETCH: begin
          if (str_q == STR_LAST) begin
            str_d   = '0;
            idx_d   = '0;
            state_d = ST_RELEASE;
          end else begin
            str_d = str_q + STR_W'(1);
          end
        end
        ST_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            gap_d           = '0;
            ch_rst_d[idx_q] = 1'b0;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              ready_d = 1'b1;
              state_d = ST_RUN;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ch_rst   = ch_rst_q;
  assign ready    = ready_q;
  assign lost_cnt = lost_q;
  assign state    = state_q;

endmodule

// File: tb/tb_sysmgr_rst_seq.sv
// tb/tb_sysmgr_rst_seq.sv - self-checking bench for the reset sequencer against a behavioural model
module tb_sysmgr_rst_seq;

  localparam int N_CH      = 3;
  localparam int LOCK_FILT = 4;
  localparam int STRETCH   = 8;
  localparam int GAP       = 4;
  localparam int LOST_W    = 8;
  localparam int LOST_MAX  = (1 << LOST_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pll_lock = 1'b0;
  logic              sw_rst_req = 1'b0;
  logic [N_CH-1:0]   ch_rst;
  logic              ready;
  logic [LOST_W-1:0] lost_cnt;
  logic [1:0]        state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sysmgr_rst_seq #(
    .N_CH      (N_CH),
    .LOCK_FILT (LOCK_FILT),
    .STRETCH   (STRETCH),
    .GAP       (GAP),
    .LOST_W    (LOST_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .sw_rst_req (sw_rst_req),
    .ch_rst     (ch_rst),
    .ready      (ready),
    .lost_cnt   (lost_cnt),
    .state      (state)
  );

  // Model: phase 0..3, cycles spent in phase, number of channels released so far.
  typedef struct {
    logic s0;
    logic s1;
    int   phase;
    int   filt;
    int   tin;
    int   released;
    int   lost;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r.s0 = 1'b0; r.s1 = 1'b0; r.phase = 0; r.filt = 0;
    r.tin = 0; r.released = 0; r.lost = 0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t m, input logic lock_in, input logic sw);
    model_t n;
    logic   ls;
    n  = m;
    ls = m.s1;
    n.s0 = lock_in;
    n.s1 = m.s0;
    if (m.phase == 0) begin
      if (!ls) n.filt = 0;
      else if (m.filt + 1 == LOCK_FILT) begin n.phase = 1; n.filt = 0; n.tin = 0; end
      else n.filt = m.filt + 1;
    end else if (!ls) begin
      n.phase = 0; n.filt = 0; n.tin = 0; n.released = 0;
      n.lost = (m.lost < LOST_MAX) ? m.lost + 1 : LOST_MAX;
    end else if (sw) begin
      n.phase = 1; n.tin = 0; n.released = 0;
    end else if (m.phase == 1) begin
      if (m.tin + 1 == STRETCH) begin n.phase = 2; n.tin = 0; end
      else n.tin = m.tin + 1;
    end else if (m.phase == 2) begin
      if (m.tin + 1 == GAP) begin
        n.tin = 0;
        n.released = m.released + 1;
        if (n.released == N_CH) n.phase = 3;
      end else n.tin = m.tin + 1;
    end
    return n;
  endfunction

  function automatic logic [N_CH-1:0] exp_ch(input int released);
    logic [N_CH-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i] = (i >= released);
    return r;
  endfunction

  model_t m;
  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, pll_lock, sw_rst_req);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("model_ch_rst", 32'(ch_rst), 32'(exp_ch(m.released)));
    check("model_ready", 32'(ready), 32'(m.phase == 3));
    check("model_state", 32'(state), 32'(m.phase));
    check("model_lost", 32'(lost_cnt), 32'(m.lost));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Hand-derived release schedule for defaults, edge 0 = edge at which pll_lock rose.
  function automatic int lit_ch(input int e);
    return (e < 18) ? 7 : (e < 22) ? 6 : (e < 26) ? 4 : 0;
  endfunction

  // Caller raises pll_lock right after edge 0.
  task automatic lock_seq(input string tag);
    for (int e = 1; e <= 26; e++) begin
      tick();
      check({tag, "_ch_rst"}, 32'(ch_rst), 32'(lit_ch(e)));
      if (e == 5)  check({tag, "_st5"}, 32'(state), 32'd0);
      if (e == 6)  check({tag, "_st6"}, 32'(state), 32'd1);
      if (e == 13) check({tag, "_st13"}, 32'(state), 32'd1);
      if (e == 14) check({tag, "_st14"}, 32'(state), 32'd2);
      if (e == 25) check({tag, "_rdy25"}, 32'(ready), 32'd0);
      if (e == 26) begin
        check({tag, "_rdy26"}, 32'(ready), 32'd1);
        check({tag, "_st26"}, 32'(state), 32'd3);
      end
    end
  endtask

  int exp_lost;

  initial begin
    exp_lost = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ch_rst", 32'(ch_rst), 32'h7);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_lost", 32'(lost_cnt), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst = 1'b0;
    ticks(3);

    // Basic sequence from lock rise.
    pll_lock = 1'b1;
    lock_seq("seq1");
    check("seq1_lost", 32'(lost_cnt), 32'd0);

    // Lock loss in RUN for 5 cycles, then re-lock.
    pll_lock = 1'b0;
    ticks(2);
    check("loss_st_e2", 32'(state), 32'd3);
    tick();
    exp_lost = 1;
    check("loss_st", 32'(state), 32'd0);
    check("loss_ch", 32'(ch_rst), 32'h7);
    check("loss_rdy", 32'(ready), 32'd0);
    check("loss_lost", 32'(lost_cnt), 32'(exp_lost));
    ticks(2);
    pll_lock = 1'b1;
    lock_seq("relock");

    // Filter restart: 3 high, 1 low, then high again.
    pll_lock = 1'b0;
    ticks(6);
    exp_lost = 2;
    pll_lock = 1'b1;
    ticks(3);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      tick();
      check("filt_ch_rst", 32'(ch_rst), 32'(lit_ch(e)));
      if (e <= 2) check("filt_no_early", 32'(state), 32'd0);
    end
    check("filt_lost", 32'(lost_cnt), 32'(exp_lost));

    // Software request from RUN, then again in RELEASE after ch 0 released.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("sw1_st", 32'(state), 32'd1);
    check("sw1_ch", 32'(ch_rst), 32'h7);
    for (int e = 1; e <= 13; e++) begin
      tick();
      check("sw1_ch_rst", 32'(ch_rst), (e < 12) ? 32'h7 : 32'h6);
      if (e == 8) check("sw1_st8", 32'(state), 32'd2);
    end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    check("sw2_st", 32'(state), 32'd1);
    check("sw2_ch", 32'(ch_rst), 32'h7);
    check("sw2_lost", 32'(lost_cnt), 32'(exp_lost));
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 11) check("sw2_ch11", 32'(ch_rst), 32'h7);
      if (e == 12) check("sw2_ch12", 32'(ch_rst), 32'h6);
    end
    check("sw2_run", 32'(state), 32'd3);

    // sw_rst_req on the same cycle lock_s drops.
    pll_lock = 1'b0;
    ticks(2);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    exp_lost = 3;
    check("both_st", 32'(state), 32'd0);
    check("both_lost", 32'(lost_cnt), 32'(exp_lost));
    ticks(3);
    pll_lock = 1'b1;
    lock_seq("seq3");

    // Sub-cycle glitch never sampled.
    pll_lock = 1'b0;
    #2;
    pll_lock = 1'b1;
    ticks(5);
    check("glitch_st", 32'(state), 32'd3);
    check("glitch_lost", 32'(lost_cnt), 32'(exp_lost));

    // Saturation of lost_cnt.
    pll_lock = 1'b0;
    ticks(6);
    exp_lost = 4;
    check("sat_pre", 32'(lost_cnt), 32'(exp_lost));
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1;
      ticks(7);
      pll_lock = 1'b0;
      ticks(3);
      if (i == 99) check("sat_mid", 32'(lost_cnt), 32'(exp_lost + 100));
    end
    check("sat_final", 32'(lost_cnt), 32'(LOST_MAX));

    // Asynchronous reset mid-RELEASE.
    pll_lock = 1'b1;
    ticks(20);
    check("arst_pre_st", 32'(state), 32'd2);
    check("arst_pre_ch", 32'(ch_rst), 32'h6);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ch", 32'(ch_rst), 32'h7);
    check("arst_rdy", 32'(ready), 32'd0);
    check("arst_lost", 32'(lost_cnt), 32'd0);
    check("arst_st", 32'(state), 32'd0);
    ticks(2);
    rst = 1'b0;
    ticks(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
